// File: rtl/memory2_stage_pkg.sv
// Shared codes for the Memory2 stage: memory op, access size, FSM states.
package memory2_stage_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int         NL_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        DRAIN = 2'b10
    } mem2_state_t;

    // Size 11 is treated as a word access everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        if (size == SZ_BYTE)
            return 1'b0;
        else if (size == SZ_HALF)
            return addr[0];
        else
            return addr != 2'b00;
    endfunction

endpackage

// File: rtl/memory2_stage_load_align.sv
// Selects the addressed byte/half/word from a DCache word and sign/zero-extends it.
module load_align
    import memory2_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*addr +: 8];
        half_sel = rdata[16*addr[1] +: 16];
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory2_stage.sv
// Memory2 pipeline stage: waits for DCache response, aligns load data, drives writeback.
// Optional misalignment exception enabled by defining MEM2_MISALIGN_CHECK_EN.
module memory2_stage
    import memory2_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] ex_result_RegInput,
    input  logic [4:0]  rd_index_RegInput,
    input  logic [2:0]  number_length_RegInput,
    input  logic [1:0]  memory_rw_RegInput,
    input  logic        writeback_valid_RegInput,
    input  logic        writeback_src_RegInput,
    input  logic        stall_RegInput,
    input  logic        clear_RegInput,
    input  logic [31:0] dcache_rdata,
    input  logic        dcache_resp_valid,
    output logic [31:0] ex_result,
    output logic [4:0]  rd_index,
    output logic [31:0] wb_data,
    output logic        writeback_valid,
    output logic        stall_req,
    output logic        ale
);

    mem2_state_t state;
    logic        valid;
    logic [2:0]  nl_r;
    logic [1:0]  rw_r;
    logic        wbv_r;
    logic        src_r;
    logic [31:0] rdata_r;
    logic [31:0] load_data;
    logic [1:0]  rw_in;
    logic        mis_in;

    // Illegal op code 11 behaves as "no memory op".
    assign rw_in = (memory_rw_RegInput == 2'b11) ? MEM_NONE : memory_rw_RegInput;

`ifdef MEM2_MISALIGN_CHECK_EN
    assign mis_in = (rw_in != MEM_NONE) &&
                    is_misaligned(number_length_RegInput[1:0], ex_result_RegInput[1:0]);
    assign ale    = valid && (rw_r != MEM_NONE) && is_misaligned(nl_r[1:0], ex_result[1:0]);
`else
    assign mis_in = 1'b0;
    assign ale    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            valid     <= 1'b0;
            ex_result <= '0;
            rd_index  <= '0;
            nl_r      <= '0;
            rw_r      <= '0;
            wbv_r     <= 1'b0;
            src_r     <= 1'b0;
            rdata_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_RegInput) begin
                        valid <= 1'b0;
                    end else if (!stall_RegInput) begin
                        valid     <= 1'b1;
                        ex_result <= ex_result_RegInput;
                        rd_index  <= rd_index_RegInput;
                        nl_r      <= number_length_RegInput;
                        rw_r      <= rw_in;
                        wbv_r     <= writeback_valid_RegInput;
                        src_r     <= writeback_src_RegInput;
                        // A misaligned access never issues, so there is nothing to wait for.
                        if (rw_in != MEM_NONE && !mis_in)
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    // The response is accepted regardless of stall_RegInput.
                    if (dcache_resp_valid) begin
                        if (clear_RegInput)
                            valid <= 1'b0;
                        else if (rw_r == MEM_LOAD)
                            rdata_r <= dcache_rdata;
                        state <= IDLE;
                    end else if (clear_RegInput) begin
                        valid <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dcache_resp_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    load_align u_load_align (
        .rdata       (rdata_r),
        .addr        (ex_result[1:0]),
        .size        (nl_r[1:0]),
        .is_unsigned (nl_r[NL_UNSIGNED_BIT]),
        .data        (load_data)
    );

    assign wb_data         = src_r ? load_data : ex_result;
    assign stall_req       = (state != IDLE);
    assign writeback_valid = valid && wbv_r && (state == IDLE) && !ale;

endmodule

// File: tb/tb_memory2_stage.sv
// Directed self-checking bench for memory2_stage.
module tb_memory2_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ex_result_RegInput;
    logic [4:0]  rd_index_RegInput;
    logic [2:0]  number_length_RegInput;
    logic [1:0]  memory_rw_RegInput;
    logic        writeback_valid_RegInput;
    logic        writeback_src_RegInput;
    logic        stall_RegInput;
    logic        clear_RegInput;
    logic [31:0] dcache_rdata;
    logic        dcache_resp_valid;
    logic [31:0] ex_result;
    logic [4:0]  rd_index;
    logic [31:0] wb_data;
    logic        writeback_valid;
    logic        stall_req;
    logic        ale;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory2_stage dut (
        .clk                      (clk),
        .rstn                     (rstn),
        .ex_result_RegInput       (ex_result_RegInput),
        .rd_index_RegInput        (rd_index_RegInput),
        .number_length_RegInput   (number_length_RegInput),
        .memory_rw_RegInput       (memory_rw_RegInput),
        .writeback_valid_RegInput (writeback_valid_RegInput),
        .writeback_src_RegInput   (writeback_src_RegInput),
        .stall_RegInput           (stall_RegInput),
        .clear_RegInput           (clear_RegInput),
        .dcache_rdata             (dcache_rdata),
        .dcache_resp_valid        (dcache_resp_valid),
        .ex_result                (ex_result),
        .rd_index                 (rd_index),
        .wb_data                  (wb_data),
        .writeback_valid          (writeback_valid),
        .stall_req                (stall_req),
        .ale                      (ale)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ex, input logic [4:0] rd, input logic [2:0] nl,
                         input logic [1:0] rw, input logic wbv, input logic src);
        ex_result_RegInput       = ex;
        rd_index_RegInput        = rd;
        number_length_RegInput   = nl;
        memory_rw_RegInput       = rw;
        writeback_valid_RegInput = wbv;
        writeback_src_RegInput   = src;
    endtask

    task automatic bubble();
        drive(32'h0, 5'd0, 3'b000, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bubble();
        stall_RegInput = 0; clear_RegInput = 0; dcache_rdata = 0; dcache_resp_valid = 0;
        #12;
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
        checks++; if (writeback_valid !== 1'b0 || stall_req !== 1'b0 || ale !== 1'b0) begin
            errors++; $display("FAIL reset_flags got wbv=%b stall=%b ale=%b exp 0", writeback_valid, stall_req, ale); end
        checks++; if (ex_result !== 32'h0 || rd_index !== 5'd0) begin
            errors++; $display("FAIL reset_regs got ex=%h rd=%0d exp 0", ex_result, rd_index); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_alu();
        drive(32'h1234_5678, 5'd3, 3'b010, 2'b00, 1'b1, 1'b0);
        step();
        bubble();
        checks++; if (wb_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_wb_data got %h exp 12345678", wb_data); end
        checks++; if (writeback_valid !== 1'b1 || stall_req !== 1'b0) begin
            errors++; $display("FAIL alu_flags got wbv=%b stall=%b exp wbv=1 stall=0", writeback_valid, stall_req); end
        checks++; if (rd_index !== 5'd3) begin errors++; $display("FAIL alu_rd got %0d exp 3", rd_index); end
        // Illegal op code 11 behaves as an ALU op: no stall.
        drive(32'h0000_0042, 5'd4, 3'b010, 2'b11, 1'b1, 1'b0);
        step();
        bubble();
        checks++; if (stall_req !== 1'b0 || writeback_valid !== 1'b1 || wb_data !== 32'h42) begin
            errors++; $display("FAIL rw11_as_none got stall=%b wbv=%b wb=%h exp 0 1 00000042", stall_req, writeback_valid, wb_data); end
    endtask

    task automatic test_load_byte();
        int stall_cycles = 0;
        drive(32'h1000_0003, 5'd5, 3'b000, 2'b01, 1'b1, 1'b1);
        step();
        bubble();
        if (stall_req === 1'b1) stall_cycles++;
        checks++; if (writeback_valid !== 1'b0) begin errors++; $display("FAIL lb_wait_wbv got %b exp 0", writeback_valid); end
        step();
        if (stall_req === 1'b1) stall_cycles++;
        dcache_rdata = 32'h80FF_0000; dcache_resp_valid = 1'b1;
        step();
        dcache_resp_valid = 1'b0; dcache_rdata = 32'h0;
        checks++; if (stall_cycles != 2 || stall_req !== 1'b0) begin
            errors++; $display("FAIL lb_stall got cycles=%0d stall_now=%b exp 2 0", stall_cycles, stall_req); end
        checks++; if (wb_data !== 32'hFFFF_FF80 || writeback_valid !== 1'b1) begin
            errors++; $display("FAIL lb_data got %h wbv=%b exp ffffff80 1", wb_data, writeback_valid); end
        step();
        checks++; if (writeback_valid !== 1'b0) begin errors++; $display("FAIL lb_bubble_wbv got %b exp 0", writeback_valid); end
    endtask

    task automatic test_load_half_word();
        drive(32'h1000_0002, 5'd6, 3'b101, 2'b01, 1'b1, 1'b1);
        step();
        bubble();
        dcache_rdata = 32'h8001_1234; dcache_resp_valid = 1'b1;
        step();
        dcache_resp_valid = 1'b0;
        checks++; if (wb_data !== 32'h0000_8001 || writeback_valid !== 1'b1) begin
            errors++; $display("FAIL lhu_data got %h wbv=%b exp 00008001 1", wb_data, writeback_valid); end
        drive(32'h1000_0000, 5'd7, 3'b010, 2'b01, 1'b1, 1'b1);
        step();
        bubble();
        dcache_rdata = 32'hDEAD_BEEF; dcache_resp_valid = 1'b1;
        step();
        dcache_resp_valid = 1'b0;
        checks++; if (wb_data !== 32'hDEAD_BEEF || writeback_valid !== 1'b1) begin
            errors++; $display("FAIL lw_data got %h wbv=%b exp deadbeef 1", wb_data, writeback_valid); end
    endtask

    task automatic test_clear_wait();
        int stall_cycles = 0;
        drive(32'h1000_0000, 5'd8, 3'b010, 2'b01, 1'b1, 1'b1);
        step();
        bubble();
        clear_RegInput = 1'b1;
        step();
        clear_RegInput = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (stall_req === 1'b1 && writeback_valid === 1'b0) stall_cycles++;
            if (i == 2) begin dcache_rdata = 32'h5555_AAAA; dcache_resp_valid = 1'b1; end
            step();
        end
        dcache_resp_valid = 1'b0;
        checks++; if (stall_cycles != 3) begin errors++; $display("FAIL drain_stall got %0d cycles exp 3", stall_cycles); end
        checks++; if (stall_req !== 1'b0 || writeback_valid !== 1'b0) begin
            errors++; $display("FAIL drain_exit got stall=%b wbv=%b exp 0 0", stall_req, writeback_valid); end
        drive(32'h0000_A5A5, 5'd9, 3'b010, 2'b00, 1'b1, 1'b0);
        step();
        bubble();
        checks++; if (writeback_valid !== 1'b1 || wb_data !== 32'h0000_A5A5) begin
            errors++; $display("FAIL after_drain got wbv=%b wb=%h exp 1 0000a5a5", writeback_valid, wb_data); end
        // Clear and response together in WAIT: back to IDLE with nothing written.
        drive(32'h1000_0000, 5'd10, 3'b010, 2'b01, 1'b1, 1'b1);
        step();
        bubble();
        clear_RegInput = 1'b1; dcache_resp_valid = 1'b1;
        step();
        clear_RegInput = 1'b0; dcache_resp_valid = 1'b0;
        checks++; if (stall_req !== 1'b0 || writeback_valid !== 1'b0) begin
            errors++; $display("FAIL clear_resp got stall=%b wbv=%b exp 0 0", stall_req, writeback_valid); end
    endtask

    task automatic test_store_stall();
        drive(32'h2000_0040, 5'd7, 3'b010, 2'b10, 1'b0, 1'b0);
        step();
        drive(32'hFFFF_FFFF, 5'd31, 3'b000, 2'b00, 1'b1, 1'b0);
        stall_RegInput = 1'b1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL st_wait got stall=%b exp 1", stall_req); end
        dcache_resp_valid = 1'b1;
        step();
        dcache_resp_valid = 1'b0;
        checks++; if (stall_req !== 1'b0 || writeback_valid !== 1'b0) begin
            errors++; $display("FAIL st_ack got stall=%b wbv=%b exp 0 0", stall_req, writeback_valid); end
        step();
        checks++; if (ex_result !== 32'h2000_0040 || rd_index !== 5'd7 || writeback_valid !== 1'b0) begin
            errors++; $display("FAIL st_hold got ex=%h rd=%0d wbv=%b exp 20000040 7 0", ex_result, rd_index, writeback_valid); end
        stall_RegInput = 1'b0;
        bubble();
        step();
    endtask

    task automatic test_misalign();
        drive(32'h1000_0002, 5'd12, 3'b010, 2'b01, 1'b1, 1'b1);
        step();
        bubble();
`ifdef MEM2_MISALIGN_CHECK_EN
        checks++; if (ale !== 1'b1 || writeback_valid !== 1'b0 || stall_req !== 1'b0) begin
            errors++; $display("FAIL misalign got ale=%b wbv=%b stall=%b exp 1 0 0", ale, writeback_valid, stall_req); end
        step();
        checks++; if (ale !== 1'b0) begin errors++; $display("FAIL misalign_clear got ale=%b exp 0", ale); end
`else
        checks++; if (ale !== 1'b0 || stall_req !== 1'b1) begin
            errors++; $display("FAIL misalign_off got ale=%b stall=%b exp 0 1", ale, stall_req); end
        dcache_rdata = 32'h0BAD_F00D; dcache_resp_valid = 1'b1;
        step();
        dcache_resp_valid = 1'b0;
        checks++; if (wb_data !== 32'h0BAD_F00D || writeback_valid !== 1'b1) begin
            errors++; $display("FAIL misalign_off_data got %h wbv=%b exp 0badf00d 1", wb_data, writeback_valid); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        drive(32'h1000_0000, 5'd13, 3'b010, 2'b01, 1'b1, 1'b1);
        step();
        bubble();
        rstn = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b0 || wb_data !== 32'h0 || rd_index !== 5'd0) begin
            errors++; $display("FAIL reset_mid_wait got stall=%b wb=%h rd=%0d exp 0 0 0", stall_req, wb_data, rd_index); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_load_half_word();
        test_clear_wait();
        test_store_stall();
        test_misalign();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
